// File: rtl/mul_shiftadd_pkg.sv
// Shared definitions for the shift-add multiplier: FSM encoding, default
// operand width and a clog2 helper for sizing the step counter.
package mul_shiftadd_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mul_shiftadd.sv
// Sequential unsigned multiplier: one shift-add step per cycle, fixed
// latency of DATA_W cycles from the accepting edge to done.
//
// The remaining multiplier bits live in the low half of the accumulator:
// each step consumes the accumulator LSB and shifts the whole register right,
// so after DATA_W steps the accumulator holds the full 2*DATA_W product.
module mul_shiftadd
    import mul_shiftadd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    output logic [2*DATA_W-1:0]   product,
    output logic                  busy,
    output logic                  done
);

    localparam int               CNT_W     = clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    state_t                state_q;
    state_t                state_nxt;
    logic [DATA_W-1:0]     a_q;
    logic [2*DATA_W-1:0]   acc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_W:0]       sum;
    logic                  accept;

    // A new operation may start from IDLE or DONE, never while iterating.
    assign accept = start && (state_q != BUSY);

    // Single DATA_W+1-bit adder: upper half plus A when the current multiplier bit is set.
    always_comb begin
        sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]};
        if (acc_q[0]) begin
            sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, a_q};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_nxt;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt_q == LAST_STEP) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_nxt = BUSY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then one shift-add step per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand and accumulator registers are reset too, so nothing
            // from an interrupted operation survives into the next one.
            a_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            a_q   <= multiplicand;
            acc_q <= {{DATA_W{1'b0}}, multiplier};
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            acc_q <= {sum, acc_q[DATA_W-1:1]};
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Only a finished result is ever visible on the product port.
    assign product = (state_q == DONE) ? acc_q : '0;

endmodule

// File: tb/tb_mul_shiftadd.sv
// Self-checking bench for mul_shiftadd: directed scenarios on an 8-bit
// instance and randomized back-to-back operations on a 32-bit instance,
// both checked against plain A*B arithmetic.
module tb_mul_shiftadd;
    import mul_shiftadd_pkg::*;

    localparam int W8  = 8;
    localparam int W32 = DATA_W_DEF;

    logic                clk;
    logic                rst_n;

    logic                s8;
    logic [W8-1:0]       a8;
    logic [W8-1:0]       b8;
    logic [2*W8-1:0]     prod8;
    logic                busy8;
    logic                done8;

    logic                s32;
    logic [W32-1:0]      a32;
    logic [W32-1:0]      b32;
    logic [2*W32-1:0]    prod32;
    logic                busy32;
    logic                done32;

    int n_checks;
    int n_bad;

    mul_shiftadd #(.DATA_W(W8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (s8),
        .multiplicand (a8),
        .multiplier   (b8),
        .product      (prod8),
        .busy         (busy8),
        .done         (done8)
    );

    mul_shiftadd #(.DATA_W(W32)) u_dut32 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (s32),
        .multiplicand (a32),
        .multiplier   (b32),
        .product      (prod32),
        .busy         (busy32),
        .done         (done32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (rst_n) begin
            check("excl8", {63'd0, busy8 & done8}, 64'd0);
            check("excl32", {63'd0, busy32 & done32}, 64'd0);
        end
    end

    // Present operands with start; return just after the accepting edge with
    // start dropped and the operand ports scrambled.
    task automatic start8(input logic [W8-1:0] a, input logic [W8-1:0] b, input string tag);
        s8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk); #1;
        s8 = 1'b0; a8 = W8'($urandom); b8 = W8'($urandom);
        check({tag, ".busy"}, {63'd0, busy8}, 64'd1);
        check({tag, ".done_lo"}, {63'd0, done8}, 64'd0);
    endtask

    // Count edges from the accepting edge until done, bounded.
    task automatic wait8(input int already, output int lat);
        lat = already;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op8(input logic [W8-1:0] a, input logic [W8-1:0] b, input string tag);
        int lat;
        logic [2*W8-1:0] exp;
        exp = (2*W8)'(a) * (2*W8)'(b);
        start8(a, b, tag);
        wait8(0, lat);
        check({tag, ".lat"}, 64'(lat), 64'd8);
        check({tag, ".prod"}, 64'(prod8), 64'(exp));
    endtask

    initial begin
        int lat;
        logic [W32-1:0] ra;
        logic [W32-1:0] rb;
        logic [2*W32-1:0] rexp;

        n_checks = 0;
        n_bad    = 0;
        rst_n = 1'b0;
        s8 = 1'b0; a8 = '0; b8 = '0;
        s32 = 1'b0; a32 = '0; b32 = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.prod8", 64'(prod8), 64'd0);
        check("rst.busy8", {63'd0, busy8}, 64'd0);
        check("rst.done8", {63'd0, done8}, 64'd0);
        check("rst.prod32", prod32, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle.busy8", {63'd0, busy8}, 64'd0);

        // Basic and full-scale products.
        op8(8'd3, 8'd5, "basic");
        op8(8'd255, 8'd255, "full");
        op8(8'd0, 8'd200, "zero");

        // Result and done hold while idle in DONE.
        repeat (5) @(posedge clk);
        #1;
        check("hold.done", {63'd0, done8}, 64'd1);
        check("hold.prod", 64'(prod8), 64'd0);

        // Start asserted during BUSY is ignored.
        start8(8'd9, 8'd11, "ign");
        @(posedge clk); #1;
        @(posedge clk); #1;
        s8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
        @(posedge clk); #1;
        s8 = 1'b0;
        wait8(3, lat);
        check("ign.lat", 64'(lat), 64'd8);
        check("ign.prod", 64'(prod8), 64'd99);

        // Back-to-back start on the first DONE cycle.
        start8(8'd16, 8'd16, "b2b");
        wait8(0, lat);
        check("b2b.lat", 64'(lat), 64'd8);
        check("b2b.prod", 64'(prod8), 64'd256);

        // Reset in the middle of an operation.
        start8(8'd50, 8'd3, "mid");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.prod", 64'(prod8), 64'd0);
        check("midrst.busy", {63'd0, busy8}, 64'd0);
        check("midrst.done", {63'd0, done8}, 64'd0);
        #1;
        rst_n = 1'b1;
        op8(8'd10, 8'd12, "postrst");

        // Randomized back-to-back operations on the 32-bit instance.
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0:       ra = '0;
                1:       ra = '1;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = '1;
                default: rb = $urandom;
            endcase
            rexp = 64'(ra) * 64'(rb);
            s32 = 1'b1; a32 = ra; b32 = rb;
            @(posedge clk); #1;
            s32 = 1'b0; a32 = $urandom; b32 = $urandom;
            check("rnd.busy", {63'd0, busy32}, 64'd1);
            lat = 0;
            while (!done32 && lat < 80) begin
                @(posedge clk); #1;
                lat++;
                if ($urandom_range(0, 3) == 0) begin
                    a32 = $urandom; b32 = $urandom;
                end
            end
            check("rnd.lat", 64'(lat), 64'(W32));
            check("rnd.prod", prod32, rexp);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_shiftadd.md
MUL_SHIFTADD -- requirements
Module: mul_shiftadd

Interface
REQ-001 Parameter DATA_W, default 32, operand width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle request to begin a multiplication.
REQ-005 done  output  1  high while a valid product is held.
REQ-006 multiplicand  input  DATA_W  unsigned operand A, sampled only on an accepted start.
REQ-007 multiplier  input  DATA_W  unsigned operand B, sampled only on an accepted start.
REQ-008 product  output  2*DATA_W  unsigned A*B, valid while done=1.
REQ-009 busy  output  1  high while iterations are in progress.

Function
REQ-010 FSM states: IDLE, BUSY, DONE.
REQ-011 In IDLE or DONE, start=1 at a rising edge is accepted, with these effects:
- A and B latched.
- Product register cleared.
- Step counter cleared.
- State set to BUSY.
REQ-012 Each BUSY cycle performs one step:
- If the LSB of the shifted multiplier is 1, add A to the upper DATA_W bits of the product using a DATA_W+1-bit sum, so the carry is kept.
- Shift {carry, product} right by 1.
- Shift the multiplier right by 1.
- Increment the counter.
REQ-013 After exactly DATA_W BUSY steps, the state becomes DONE; done rises at edge T0+DATA_W, where T0 is the edge that accepted start.
REQ-014 busy=1 only in BUSY.
REQ-015 done=1 only in DONE.
REQ-016 busy and done are never high together.
REQ-017 In BUSY, start is ignored; operands and the step sequence are unaffected.
REQ-018 In DONE, product and done hold indefinitely until the next accepted start.
REQ-019 start accepted in DONE: done falls at the next edge and a new operation begins (back-to-back).
REQ-020 Latency is fixed at DATA_W cycles, independent of operand values; there is no early termination for zero operands.
REQ-021 Operand changes on the input ports outside an accepted start have no effect on the result.
REQ-022 Arithmetic is unsigned throughout; product equals A*B exactly for all inputs; overflow cannot occur at 2*DATA_W.
REQ-023 The step counter width is clog2(DATA_W)+1 bits; the counter never wraps during an operation.

Reset
REQ-024 rst_n=0 asynchronously forces these values, regardless of the current state, including mid-operation:
- state = IDLE
- done = 0
- busy = 0
- product = 0
- counter = 0
- latched operands = 0
REQ-025 After rst_n rises, the block waits in IDLE for start; a start on the first edge after deassertion is accepted.
REQ-026 No partial result from an operation interrupted by reset is ever presented.

Structure
REQ-027 The shared package holds the following, consumed by both the RTL and the bench:
- FSM state encoding (2 bits: IDLE=0, BUSY=1, DONE=2).
- The DATA_W default.
- A clog2 helper constant function.
REQ-028 No sub-module: datapath (adder, shifter, counter) and FSM reside in mul_shiftadd.
REQ-029 Register count is bounded by 3*DATA_W + counter + state bits.
REQ-030 The only adder is one DATA_W+1-bit adder; there are no hardware multiplier primitives.

Verification (DATA_W=8 unless noted)
REQ-031 Basic product: A=3, B=5, start at T0 -> done=1 at T0+8, product=15; busy high T0+1..T0+8 exclusive of done.
REQ-032 Full-scale product: A=255, B=255 -> product=0xFE01; then A=0, B=200 -> product=0, with latency still 8 cycles.
REQ-033 Start ignored in BUSY: start=1 at T0+3 with A=7, B=7 -> result still A*B of the T0 operands; done at T0+8 only.
REQ-034 Back-to-back: start=1 on the first DONE cycle with A=16, B=16 -> done low next cycle, product=256 at the following done.
REQ-035 Reset mid-operation: rst_n=0 at T0+4 -> product=0, done=0, busy=0 immediately; a subsequent A=10, B=12 yields 120.
REQ-036 Randomized check: 1000 random operand pairs at DATA_W=32 -> every product equals the 64-bit reference A*B, with done exactly 32 cycles after start.
